// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment shift-chain link.
// Both the transmitter and the receiver pull their defaults from here.
package sevenseg_pkg;

  localparam int WORD_W     = 16;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  // Bit counter must hold 0..word_w+1; the top value marks an overlong frame.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 2);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register with a saturating bit counter.
// clr wins over shift_en and resets only the count; the word is left as is.
module sipo_shift #(
  parameter int WORD_W = sevenseg_pkg::WORD_W,
  parameter int CNT_W  = sevenseg_pkg::cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  input  logic              shift_en,
  input  logic              clr,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WORD_W + 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      word <= {word[WORD_W-2:0], sdi};
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sevenseg_serial_rx.sv
// Receiver end of the seven-segment PISO link: rebuilds each serial word and
// files it into a rotating digit buffer, flagging frames with a wrong bit count.
module sevenseg_serial_rx #(
  parameter int WORD_W     = sevenseg_pkg::WORD_W,
  parameter int NUM_DIGITS = sevenseg_pkg::NUM_DIGITS,
  parameter int IDX_W      = sevenseg_pkg::IDX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sdi,
  input  logic                         latch,
  output logic [NUM_DIGITS*WORD_W-1:0] digits,
  output logic [IDX_W-1:0]             slot_idx,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic                         scan_done
);

  localparam int               CNT_W     = sevenseg_pkg::cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WORD_W);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_DIGITS - 1);

  logic              latch_d;
  logic              latch_rise;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  bit_cnt;

  assign latch_rise = latch & ~latch_d;

  // Latch high suppresses shifting for its whole duration, rise cycle included.
  sipo_shift #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .sdi      (sdi),
    .shift_en (~latch),
    .clr      (latch_rise),
    .word     (word),
    .cnt      (bit_cnt)
  );

  // NOTE: the digit buffer is a handful of flops rather than a RAM, so it is
  // reset with everything else and reads back as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_d     <= 1'b0;
      digits      <= '0;
      slot_idx    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      latch_d     <= latch;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      scan_done   <= 1'b0;
      if (latch_rise) begin
        if (bit_cnt == CNT_FULL) begin
          digits[slot_idx*WORD_W +: WORD_W] <= word;
          frame_valid <= 1'b1;
          scan_done   <= (slot_idx == LAST_SLOT);
          slot_idx    <= (slot_idx == LAST_SLOT) ? '0 : slot_idx + 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_serial_rx.sv
// Directed bench for sevenseg_serial_rx: a reference model pushes expected
// frame outcomes to a scoreboard, popped when the DUT pulses valid or err.
module tb_sevenseg_serial_rx;
  import sevenseg_pkg::*;

  localparam int W = WORD_W;
  localparam int N = NUM_DIGITS;

  typedef struct {
    logic             good;
    logic             scan;
    logic [N*W-1:0]   digits;
    logic [IDX_W-1:0] slot;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sdi = 1'b0;
  logic             latch = 1'b0;
  logic [N*W-1:0]   digits;
  logic [IDX_W-1:0] slot_idx;
  logic             frame_valid;
  logic             frame_err;
  logic             scan_done;

  int checks   = 0;
  int failures = 0;

  exp_t             sb[$];
  logic [N*W-1:0]   m_digits = '0;
  logic [IDX_W-1:0] m_slot   = '0;

  sevenseg_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sdi         (sdi),
    .latch       (latch),
    .digits      (digits),
    .slot_idx    (slot_idx),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .scan_done   (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":no_pulse"}, 64'({frame_valid, frame_err, scan_done}), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":digits"}, 64'(digits), 64'd0);
    check({tag, ":slot_idx"}, 64'(slot_idx), 64'd0);
    check_quiet(tag);
  endtask

  // Assert rst between clock edges and look at the outputs before the next edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state(tag);
    m_digits = '0;
    m_slot   = '0;
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      sdi   = val[i];
      latch = 1'b0;
      @(posedge clk);
      #1 check_quiet({tag, ":shift"});
    end
  endtask

  task automatic push_expected(input int n);
    exp_t e;
    e.good = (n == W);
    e.scan = e.good && (m_slot == IDX_W'(N - 1));
    sb.push_back(e);
  endtask

  // Pop one expected outcome once the DUT shows a frame pulse and compare.
  task automatic expect_pulse(input string tag);
    exp_t e;
    check({tag, ":pulse_seen"}, 64'(frame_valid | frame_err), 64'd1);
    if ((frame_valid || frame_err) && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":frame_valid"}, 64'(frame_valid), 64'(e.good));
      check({tag, ":frame_err"}, 64'(frame_err), 64'(!e.good));
      check({tag, ":scan_done"}, 64'(scan_done), 64'(e.scan));
      check({tag, ":digits"}, 64'(digits), 64'(e.digits));
      check({tag, ":slot_idx"}, 64'(slot_idx), 64'(e.slot));
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int n, input int hold,
                            input string tag);
    shift_bits(val, n, tag);
    push_expected(n);
    if (n == W) begin
      m_digits[m_slot*W +: W] = val[W-1:0];
      m_slot = m_slot + 1'b1;
    end
    sb[sb.size()-1].digits = m_digits;
    sb[sb.size()-1].slot   = m_slot;
    latch = 1'b1;
    sdi   = ~sdi;
    @(posedge clk);
    #1 expect_pulse(tag);
    for (int h = 1; h < hold; h++) begin
      sdi = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 check_quiet({tag, ":hold"});
      check({tag, ":hold_slot"}, 64'(slot_idx), 64'(m_slot));
    end
    latch = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    #1 rst = 1'b1;
    #1 check_reset_state("init_reset");
    m_digits = '0;
    m_slot   = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    send_frame(32'hA5C3, 16, 1, "good_a5c3");

    // Asynchronous reset clears the buffer filled above.
    pulse_reset("async_reset");

    send_frame(32'h1111, 16, 1, "scan_w0");
    send_frame(32'h2222, 16, 1, "scan_w1");
    send_frame(32'h3333, 16, 1, "scan_w2");
    send_frame(32'h4444, 16, 1, "scan_w3");
    check("scan_full_buffer", 64'(digits), 64'h4444_3333_2222_1111);
    send_frame(32'h5555, 16, 1, "scan_wrap");

    // Framing errors leave the slot and buffer alone.
    send_frame(32'h7FFF, 15, 1, "err_short15");
    send_frame(32'hF_A5A5, 20, 1, "err_long20");
    send_frame(32'h1, 1, 1, "err_btb1");
    send_frame(32'hCAFE, 16, 1, "good_after_err");

    // Long latch: one capture only, sdi ignored while latch stays high.
    send_frame(32'hBEEF, 16, 3, "long_latch");
    send_frame(32'h1234, 16, 1, "after_long_latch");

    // Reset partway through a frame discards the partial word.
    shift_bits(32'hFF, 8, "partial");
    pulse_reset("midframe_reset");
    send_frame(32'h0F0F, 16, 1, "post_reset_0f0f");

    // Zero-bit frame: latch already high when reset releases.
    latch = 1'b1;
    pulse_reset("zero_len_reset");
    push_expected(0);
    sb[sb.size()-1].digits = m_digits;
    sb[sb.size()-1].slot   = m_slot;
    @(posedge clk);
    #1 expect_pulse("err_zero_len");
    latch = 1'b0;
    send_frame(32'h9876, 16, 1, "good_after_zero");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
